// File: rtl/simm_array_controller_if.sv
// Bus bundle between device decode, the SIMM array controller and the SIMM pins.
// Decode/bench side is the master; the controller is the slave.
interface simm_array_controller_if #(
  parameter int SLOTS     = 2,
  parameter int SLOT_BITS = 1,
  parameter int ROW_BITS  = 12
);
  logic                   cs;
  logic                   read;
  logic                   write;
  logic [SLOT_BITS-1:0]   slot;
  logic                   side;
  logic [ROW_BITS-1:0]    row;
  logic [3:0]             byte_selects;
  logic [2*SLOTS-1:0]     ras;
  logic [3:0]             cas;
  logic                   mux_select;
  logic                   waitstate;
  logic                   refresh_busy;

  modport master (
    output cs, read, write, slot, side, row, byte_selects,
    input  ras, cas, mux_select, waitstate, refresh_busy
  );

  modport slave (
    input  cs, read, write, slot, side, row, byte_selects,
    output ras, cas, mux_select, waitstate, refresh_busy
  );
endinterface

// File: rtl/simm_array_controller.sv
// FPM DRAM controller for SLOTS SIMM slots (two RAS sides each) with
// CAS-before-RAS refresh, programmable precharge / CAS wait and abort on
// bus-cycle withdrawal. Outputs are registered: each state's actions become
// visible on the edge taken while in that state.
// Optional macro SIMM_PAGE_MODE_EN: keep the page open after an access and
// serve same slot/side/row accesses straight from CAS.
module simm_array_controller #(
  parameter int SLOTS       = 2,
  parameter int SLOT_BITS   = 1,
  parameter int ROW_BITS    = 12,
  parameter int REFRESH_DIV = 250,
  parameter int CAS_WAIT    = 1,
  parameter int TRP         = 2
) (
  input  logic                    clock,
  input  logic                    n_reset,
  simm_array_controller_if.slave  bus
);
  localparam int NRAS = 2 * SLOTS;
  localparam int RCW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_ROW, S_MUX, S_CAS, S_DONE, S_PRE,
    S_REF_CAS, S_REF_RAS1, S_REF_RAS2
`ifdef SIMM_PAGE_MODE_EN
    , S_OPEN
`endif
  } state_t;

  state_t                r_state;
  logic [NRAS-1:0]       r_ras;
  logic [3:0]            r_cas;
  logic                  r_mux;
  logic                  r_wait;
  logic                  r_busy;
  logic [1:0]            r_pending;
  logic [2:0]            r_cnt;
  logic [RCW-1:0]        r_ref_cnt;
  logic [SLOT_BITS-1:0]  r_slot;
  logic                  r_side;
  logic                  r_rd;

  logic                  w_req;
  logic                  w_tick;
  logic                  w_inc;
  logic                  w_ref_go;
  logic                  w_close;
  logic                  w_lane_ok;
  logic [NRAS-1:0]       w_ras_sel;

`ifdef SIMM_PAGE_MODE_EN
  logic [ROW_BITS-1:0]   r_row;
  logic                  w_hit;
  assign w_hit = (bus.slot == r_slot) && (bus.side == r_side) && (bus.row == r_row);
`else
  logic                  w_unused_row;
  assign w_unused_row = ^bus.row;
`endif

  assign w_req    = bus.cs && (bus.read || bus.write);
  assign w_tick   = (r_ref_cnt == '0);
  assign w_inc    = w_tick && (r_pending != 2'd3);
  assign w_ref_go = (r_state == S_IDLE) && (r_pending != 2'd0);

  // One-hot RAS select from latched slot/side; out-of-range slots select nothing.
  always_comb begin
    w_ras_sel = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (r_slot == SLOT_BITS'(i)) begin
        w_ras_sel[2*i]   = !r_side;
        w_ras_sel[2*i+1] = r_side;
      end
    end
  end

  assign w_lane_ok = |w_ras_sel;

  // States that must drop everything and precharge this edge.
  always_comb begin
    w_close = 1'b0;
    case (r_state)
      S_ROW, S_MUX, S_CAS: w_close = !bus.cs;
`ifdef SIMM_PAGE_MODE_EN
      S_OPEN:              w_close = (r_pending != 2'd0) || (w_req && !w_hit);
`else
      S_DONE:              w_close = !bus.cs;
`endif
      default:             w_close = 1'b0;
    endcase
  end

  // Refresh interval down-counter, reloads on reaching zero.
  always_ff @(posedge clock) begin
    if (!n_reset)    r_ref_cnt <= RCW'(REFRESH_DIV - 1);
    else if (w_tick) r_ref_cnt <= RCW'(REFRESH_DIV - 1);
    else             r_ref_cnt <= r_ref_cnt - RCW'(1);
  end

  // Main sequencer: access, refresh and precharge, with registered pin outputs.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      r_state   <= S_IDLE;
      r_ras     <= '0;
      r_cas     <= '0;
      r_mux     <= 1'b0;
      r_wait    <= 1'b1;
      r_busy    <= 1'b0;
      r_pending <= 2'd0;
      r_cnt     <= 3'd0;
      r_slot    <= '0;
      r_side    <= 1'b0;
      r_rd      <= 1'b0;
`ifdef SIMM_PAGE_MODE_EN
      r_row     <= '0;
`endif
    end else begin
      if (w_inc && !w_ref_go)      r_pending <= r_pending + 2'd1;
      else if (!w_inc && w_ref_go) r_pending <= r_pending - 2'd1;

      if (w_close) begin
        r_ras   <= '0;
        r_cas   <= '0;
        r_mux   <= 1'b0;
        r_wait  <= 1'b1;
        r_cnt   <= 3'd0;
        r_state <= S_PRE;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_ras  <= '0;
            r_cas  <= '0;
            r_mux  <= 1'b0;
            r_wait <= 1'b1;
            if (w_ref_go) begin
              r_busy  <= 1'b1;
              r_state <= S_REF_CAS;
            end else if (w_req) begin
              r_slot  <= bus.slot;
              r_side  <= bus.side;
              r_rd    <= bus.read;
`ifdef SIMM_PAGE_MODE_EN
              r_row   <= bus.row;
`endif
              r_state <= S_ROW;
            end
          end
          S_ROW: begin
            r_ras   <= w_ras_sel;
            r_mux   <= 1'b0;
            r_state <= S_MUX;
          end
          S_MUX: begin
            r_mux   <= 1'b1;
            r_cnt   <= 3'd0;
            r_state <= S_CAS;
          end
          S_CAS: begin
            r_cas <= w_lane_ok ? (r_rd ? 4'hF : bus.byte_selects) : 4'h0;
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'(CAS_WAIT)) r_state <= S_DONE;
          end
          S_DONE: begin
            if (bus.cs) r_wait <= 1'b0;
`ifdef SIMM_PAGE_MODE_EN
            else begin
              // page stays open: RAS held, column mux kept, CAS released
              r_cas   <= '0;
              r_wait  <= 1'b1;
              r_state <= S_OPEN;
            end
`endif
          end
`ifdef SIMM_PAGE_MODE_EN
          S_OPEN: begin
            if (w_req) begin
              r_rd    <= bus.read;
              r_cnt   <= 3'd0;
              r_state <= S_CAS;
            end
          end
`endif
          S_PRE: begin
            r_ras  <= '0;
            r_cas  <= '0;
            r_mux  <= 1'b0;
            r_wait <= 1'b1;
            r_cnt  <= r_cnt + 3'd1;
            if (r_cnt == 3'(TRP - 1)) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
          S_REF_CAS: begin
            r_cas   <= 4'hF;
            r_state <= S_REF_RAS1;
          end
          S_REF_RAS1: begin
            r_ras   <= '1;
            r_state <= S_REF_RAS2;
          end
          S_REF_RAS2: begin
            r_cnt   <= 3'd0;
            r_state <= S_PRE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.ras          = r_ras;
  assign bus.cas          = r_cas;
  assign bus.mux_select   = r_mux;
  assign bus.waitstate    = r_wait;
  assign bus.refresh_busy = r_busy;
endmodule
